// File: rtl/fpu_sp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sp_pkg
//  Description : Shared definitions for the single-precision FPU scheduler:
//                opcode encoding, unit enumeration, opcode decode, order-FIFO
//                entry type, unit latencies and the arithmetic used by the
//                functional units (normal numbers, truncating rounding).
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_sp_pkg;

    localparam logic [3:0] CMD_FPU_SP_ADD = 4'h0;
    localparam logic [3:0] CMD_FPU_SP_MUL = 4'h1;
    localparam logic [3:0] CMD_FPU_SP_DIV = 4'h2;
    localparam logic [3:0] CMD_FPU_SP_F2I = 4'h3;
    localparam logic [3:0] CMD_FPU_SP_I2F = 4'h4;

    localparam int NUM_UNITS = 5;

    typedef enum logic [2:0] {
        UNIT_ADD = 3'd0,
        UNIT_MUL = 3'd1,
        UNIT_DIV = 3'd2,
        UNIT_F2I = 3'd3,
        UNIT_I2F = 3'd4
    } unit_e;

    typedef struct packed {
        logic  legal;
        unit_e unit;
    } cmd_dec_t;

    // The caller tag is appended outside this struct because its width is a
    // parameter of the scheduler instance.
    typedef struct packed {
        unit_e unit;
        logic  illegal;
    } ord_entry_t;

    // Illegal opcodes decode to UNIT_ADD so every unit index stays in range.
    function automatic cmd_dec_t cmd2unit(input logic [3:0] cmd);
        cmd_dec_t d;
        d.legal = 1'b1;
        d.unit  = UNIT_ADD;
        case (cmd)
            CMD_FPU_SP_ADD: d.unit = UNIT_ADD;
            CMD_FPU_SP_MUL: d.unit = UNIT_MUL;
            CMD_FPU_SP_DIV: d.unit = UNIT_DIV;
            CMD_FPU_SP_F2I: d.unit = UNIT_F2I;
            CMD_FPU_SP_I2F: d.unit = UNIT_I2F;
            default:        d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic int unit_lat(input unit_e u);
        case (u)
            UNIT_ADD: return 2;
            UNIT_MUL: return 3;
            UNIT_DIV: return 8;
            UNIT_F2I: return 1;
            default:  return 2;
        endcase
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b, r;
        logic [24:0] ma, mb, s;
        logic [7:0]  d;
        logic [4:0]  sh;
        // Order operands so that a has the larger magnitude.
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        d  = a[30:23] - b[30:23];
        ma = {2'b01, a[22:0]};
        mb = (b[30:23] == 8'd0) ? 25'd0 : ({2'b01, b[22:0]} >> d);
        r  = 32'd0;
        sh = 5'd0;
        s  = 25'd0;
        if (a[30:23] == 8'd0) begin
            r = 32'd0;
        end else if (a[31] == b[31]) begin
            s = ma + mb;
            if (s[24]) r = {a[31], a[30:23] + 8'd1, s[23:1]};
            else       r = {a[31], a[30:23], s[22:0]};
        end else begin
            s = ma - mb;
            // Renormalise: shift the leading one back up to bit 23.
            for (int i = 0; i < 24; i++) begin
                if (s[i]) sh = 5'(23 - i);
            end
            if ((s == 25'd0) || (a[30:23] <= {3'd0, sh})) begin
                r = 32'd0;
            end else begin
                s = s << sh;
                r = {a[31], a[30:23] - {3'd0, sh}, s[22:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [22:0] m;
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            return {a[31] ^ b[31], 31'd0};
        end
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127 + {9'd0, p[47]};
        m = p[47] ? p[46:24] : p[45:23];
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] q;
        logic [9:0]  e;
        logic [22:0] m;
        if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
            return {a[31] ^ b[31], 31'd0};
        end
        q = {1'b1, a[22:0], 24'd0} / {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd126 + {9'd0, q[24]};
        m = q[24] ? q[23:1] : q[22:0];
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    // Truncates toward zero, saturates beyond the int32 range.
    function automatic logic [31:0] fp_f2i(input logic [31:0] a);
        logic [31:0] mag;
        if (a[30:23] < 8'd127) return 32'd0;
        if (a[30:23] > 8'd157) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        if (a[30:23] >= 8'd150) mag = {8'd0, 1'b1, a[22:0]} << (a[30:23] - 8'd150);
        else                    mag = {8'd0, 1'b1, a[22:0]} >> (8'd150 - a[30:23]);
        return a[31] ? (~mag + 32'd1) : mag;
    endfunction

    function automatic logic [31:0] fp_i2f(input logic [31:0] a);
        logic [31:0] mag, n;
        logic [4:0]  p;
        if (a == 32'd0) return 32'd0;
        mag = a[31] ? (~a + 32'd1) : a;
        p   = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) p = 5'(i);
        end
        n = (p >= 5'd23) ? (mag >> (p - 5'd23)) : (mag << (5'd23 - p));
        return {a[31], 8'd127 + {3'd0, p}, n[22:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_sp_ord_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sp_ord_fifo
//  Description : Issue-order FIFO. Pointers carry one extra wrap bit so full
//                and empty are distinguished without a counter.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_push, i_data  write an entry (caller guarantees !o_full)
//                i_pop           drop the head (caller guarantees !o_empty)
//                o_head          oldest entry
//                o_full, o_empty occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_sp_ord_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + 1'b1;
            end
            if (i_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/fpu_sp_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sp_unit
//  Description : One single-precision functional unit. Operands are sampled
//                on the i_dval edge; o_rdy pulses for one cycle LAT cycles
//                later with o_result valid.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_dval          start an operation (one-cycle pulse)
//                i_din1, i_din2  operands (i_din2 unused by F2I/I2F)
//                o_rdy, o_result one-cycle completion pulse and result
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_sp_unit
    import fpu_sp_pkg::*;
#(
    parameter unit_e OP  = UNIT_ADD,
    parameter int    LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_dval,
    input  logic [31:0] i_din1,
    input  logic [31:0] i_din2,
    output logic        o_rdy,
    output logic [31:0] o_result
);

    logic [3:0]  r_cnt;
    logic [31:0] r_res;
    logic [31:0] w_calc;

    always_comb begin
        w_calc = 32'd0;
        case (OP)
            UNIT_ADD: w_calc = fp_add(i_din1, i_din2);
            UNIT_MUL: w_calc = fp_mul(i_din1, i_din2);
            UNIT_DIV: w_calc = fp_div(i_din1, i_din2);
            UNIT_F2I: w_calc = fp_f2i(i_din1);
            UNIT_I2F: w_calc = fp_i2f(i_din1);
            default:  w_calc = 32'd0;
        endcase
    end

    // Counter reaches 1 in the cycle ending at the LAT-th edge after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_res <= 32'd0;
        end else if (i_dval) begin
            r_cnt <= 4'(LAT);
            r_res <= w_calc;
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_rdy    = (r_cnt == 4'd1);
    assign o_result = r_res;

endmodule
`default_nettype wire

// File: rtl/fpu_sp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_sp_sched
//  Description : In-order, multi-issue command scheduler for the SP FPU.
//                Each accepted legal command starts its unit; results are
//                parked in a per-unit slot and released in issue order.
//  Ports       : clk, rst_n                    clock, async active-low reset
//                cmd_valid/cmd_ready           command handshake
//                cmd, din1, din2, tag_in       opcode, operands, caller tag
//                res_valid/res_ready           result handshake
//                result, res_tag, res_err      result word, tag, illegal flag
//                busy                          commands outstanding
//  Revision    : 1.0  initial release
// ============================================================================
module fpu_sp_sched
    import fpu_sp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd,
    input  logic [31:0]      din1,
    input  logic [31:0]      din2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    output logic             busy
);

    localparam int ENT_W = TAG_W + $bits(ord_entry_t);

    cmd_dec_t             w_dec;
    ord_entry_t           w_push_ent;
    ord_entry_t           w_head_ent;
    logic [ENT_W-1:0]     w_push_data;
    logic [ENT_W-1:0]     w_head_data;
    logic [TAG_W-1:0]     w_head_tag;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_acc;
    logic                 w_pop;
    logic                 w_res_valid;
    logic [NUM_UNITS-1:0] w_dval;
    logic [NUM_UNITS-1:0] w_rdy;
    logic [NUM_UNITS-1:0] w_pop_u;
    logic [31:0]          w_ures [NUM_UNITS];
    logic [NUM_UNITS-1:0] r_unit_busy;
    logic [NUM_UNITS-1:0] r_slot_full;
    logic [31:0]          r_slot [NUM_UNITS];

    // Acceptance depends only on cmd and registered state, never on res_ready,
    // so a full FIFO stays full for the cycle in which it is also popped.
    assign w_dec     = cmd2unit(cmd);
    assign cmd_ready = !w_full && (!w_dec.legal || !r_unit_busy[w_dec.unit]);
    assign w_acc     = cmd_valid && cmd_ready;

    assign w_push_ent.unit    = w_dec.unit;
    assign w_push_ent.illegal = !w_dec.legal;
    assign w_push_data        = {tag_in, w_push_ent};
    assign {w_head_tag, w_head_ent} = w_head_data;

    fpu_sp_ord_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ord_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_acc),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    for (genvar g_u = 0; g_u < NUM_UNITS; g_u++) begin : g_unit
        localparam unit_e c_u = unit_e'(g_u);

        assign w_dval[g_u]  = w_acc && w_dec.legal && (w_dec.unit == c_u);
        assign w_pop_u[g_u] = w_pop && !w_head_ent.illegal && (w_head_ent.unit == c_u);

        fpu_sp_unit #(
            .OP  (c_u),
            .LAT (unit_lat(c_u))
        ) u_unit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_dval   (w_dval[g_u]),
            .i_din1   (din1),
            .i_din2   (din2),
            .o_rdy    (w_rdy[g_u]),
            .o_result (w_ures[g_u])
        );
    end

    // A unit cannot be re-issued while busy, and its slot cannot fill while
    // already full, so set/clear never collide for the same unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unit_busy <= '0;
            r_slot_full <= '0;
            for (int u = 0; u < NUM_UNITS; u++) r_slot[u] <= 32'd0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (w_dval[u]) begin
                    r_unit_busy[u] <= 1'b1;
                end else if (w_pop_u[u]) begin
                    r_unit_busy[u] <= 1'b0;
                end
                // rdy from an idle unit is spurious and dropped.
                if (w_rdy[u] && r_unit_busy[u] && !r_slot_full[u]) begin
                    r_slot[u]      <= w_ures[u];
                    r_slot_full[u] <= 1'b1;
                end else if (w_pop_u[u]) begin
                    r_slot_full[u] <= 1'b0;
                end
            end
        end
    end

    assign w_res_valid = !w_empty && (w_head_ent.illegal || r_slot_full[w_head_ent.unit]);
    assign w_pop       = w_res_valid && res_ready;

    assign res_valid = w_res_valid;
    assign result    = (w_res_valid && !w_head_ent.illegal) ? r_slot[w_head_ent.unit] : 32'd0;
    assign res_tag   = w_empty ? '0 : w_head_tag;
    assign res_err   = !w_empty && w_head_ent.illegal;
    assign busy      = !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fpu_sp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_sp_sched
//  Description : Self-checking bench for fpu_sp_sched: vector table through a
//                result scoreboard, plus hand-written ordering, back-pressure,
//                latency, full-FIFO and reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_sp_sched;
    import fpu_sp_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
    logic [3:0]       cmd;
    logic [31:0]      din1, din2, result;
    logic [TAG_W-1:0] tag_in, res_tag;

    logic             s_cmd_valid, s_cmd_ready, s_res_valid, s_res_ready, s_res_err, s_busy;
    logic [3:0]       s_cmd;
    logic [31:0]      s_result;
    logic [TAG_W-1:0] s_tag_in, s_res_tag;

    fpu_sp_sched #(.DEPTH(8), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .din1(din1), .din2(din2), .tag_in(tag_in),
        .res_valid(res_valid), .res_ready(res_ready), .result(result),
        .res_tag(res_tag), .res_err(res_err), .busy(busy)
    );

    fpu_sp_sched #(.DEPTH(2), .TAG_W(TAG_W)) u_small (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd(s_cmd),
        .din1(32'd0), .din2(32'd0), .tag_in(s_tag_in),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .result(s_result),
        .res_tag(s_res_tag), .res_err(s_res_err), .busy(s_busy)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every handshaken result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got %08h tag %0d, expected no result", result, res_tag);
            end else begin : pop_blk
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_tag", 32'(res_tag), 32'(e.tag));
                chk("sb_err", 32'(res_err), 32'(e.err));
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t, input logic [31:0] er, input logic ee,
                        output int acc_cyc);
        exp_t e;
        bit   done;
        done    = 1'b0;
        acc_cyc = -1;
        cmd_valid = 1'b1; cmd = c; din1 = a; din2 = b; tag_in = t;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                done = 1'b1;
                e.res = er; e.tag = t; e.err = ee;
                sb.push_back(e);
                acc_cyc = cyc;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: cmd %h tag %0d never accepted", c, t);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, ca;
        vecs[0]  = '{CMD_FPU_SP_ADD, 32'h3F800000, 32'h40000000, 4'd3,  32'h40400000, 1'b0};
        vecs[1]  = '{CMD_FPU_SP_MUL, 32'h40000000, 32'h40400000, 4'd4,  32'h40C00000, 1'b0};
        vecs[2]  = '{CMD_FPU_SP_F2I, 32'h40E00000, 32'h00000000, 4'd5,  32'h00000007, 1'b0};
        vecs[3]  = '{CMD_FPU_SP_I2F, 32'h00000005, 32'h00000000, 4'd6,  32'h40A00000, 1'b0};
        vecs[4]  = '{4'hF,           32'h12345678, 32'h9ABCDEF0, 4'd7,  32'h00000000, 1'b1};
        vecs[5]  = '{CMD_FPU_SP_ADD, 32'h40400000, 32'hBF800000, 4'd8,  32'h40000000, 1'b0};
        vecs[6]  = '{CMD_FPU_SP_DIV, 32'h40C00000, 32'h40000000, 4'd9,  32'h40400000, 1'b0};
        vecs[7]  = '{CMD_FPU_SP_F2I, 32'hC0200000, 32'h00000000, 4'd10, 32'hFFFFFFFE, 1'b0};
        vecs[8]  = '{CMD_FPU_SP_I2F, 32'hFFFFFFFD, 32'h00000000, 4'd11, 32'hC0400000, 1'b0};
        vecs[9]  = '{CMD_FPU_SP_MUL, 32'h3FC00000, 32'h3FC00000, 4'd12, 32'h40100000, 1'b0};
        vecs[10] = '{4'h5,           32'h3F800000, 32'h3F800000, 4'd13, 32'h00000000, 1'b1};

        cmd_valid = 1'b0; cmd = CMD_FPU_SP_ADD; din1 = 32'd0; din2 = 32'd0; tag_in = '0;
        res_ready = 1'b0;
        s_cmd_valid = 1'b0; s_cmd = 4'hF; s_tag_in = '0; s_res_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_res_tag", 32'(res_tag), 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table, streamed with the consumer always ready.
        res_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, vecs[i].err, ca);
        end
        drain();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // DIV then MUL back-to-back: consecutive accepts, results in issue order.
        send(CMD_FPU_SP_DIV, 32'h3F800000, 32'h40800000, 4'd1, 32'h3E800000, 1'b0, c1);
        send(CMD_FPU_SP_MUL, 32'h40000000, 32'h40400000, 4'd2, 32'h40C00000, 1'b0, c2);
        chk("b2b_accept_gap", 32'(c2 - c1), 32'd1);
        drain();

        // Second ADD waits for the first to be popped, then issues one cycle later.
        res_ready = 1'b0;
        send(CMD_FPU_SP_ADD, 32'h3F800000, 32'h3F800000, 4'd5, 32'h40000000, 1'b0, ca);
        cmd_valid = 1'b1; cmd = CMD_FPU_SP_ADD; din1 = 32'h40000000; din2 = 32'h40000000; tag_in = 4'd6;
        repeat (5) @(negedge clk);
        chk("add2_blocked", 32'(cmd_ready), 32'd0);
        chk("add1_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("add2_pop_cycle", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("add2_after_pop", 32'(cmd_ready), 32'd1);
        if (cmd_ready) begin : add2_push
            exp_t e;
            e.res = 32'h40800000; e.tag = 4'd6; e.err = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // F2I then I2F under back-pressure: each result holds until popped.
        res_ready = 1'b0;
        send(CMD_FPU_SP_F2I, 32'h40E00000, 32'h0, 4'd8, 32'h00000007, 1'b0, ca);
        send(CMD_FPU_SP_I2F, 32'h00000005, 32'h0, 4'd9, 32'h40A00000, 1'b0, ca);
        repeat (6) @(negedge clk);
        chk("hold1_valid", 32'(res_valid), 32'd1);
        chk("hold1_result", result, 32'h00000007);
        repeat (3) @(negedge clk);
        chk("hold1_stable", result, 32'h00000007);
        chk("hold1_tag", 32'(res_tag), 32'd8);
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("hold2_result", result, 32'h40A00000);
        chk("hold2_tag", 32'(res_tag), 32'd9);
        @(posedge clk); #1; res_ready = 1'b1;
        drain();

        // Illegal opcode: result visible the cycle after accept.
        res_ready = 1'b0;
        send(4'hF, 32'h0, 32'h0, 4'd7, 32'h00000000, 1'b1, ca);
        @(negedge clk);
        chk("ill_valid", 32'(res_valid), 32'd1);
        chk("ill_result", result, 32'd0);
        chk("ill_err", 32'(res_err), 32'd1);
        chk("ill_tag", 32'(res_tag), 32'd7);
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;

        // Single-cycle F2I: rdy cycle, then slot, then res_valid.
        send(CMD_FPU_SP_F2I, 32'h3F800000, 32'h0, 4'd4, 32'h00000001, 1'b0, ca);
        @(negedge clk);
        chk("f2i_lat_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("f2i_lat_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1; res_ready = 1'b1;
        drain();

        // DEPTH=2 instance: fill with illegal opcodes, then push+pop while full.
        s_cmd_valid = 1'b1; s_cmd = 4'hF; s_tag_in = 4'd1;
        @(posedge clk); #1; s_tag_in = 4'd2;
        @(posedge clk); #1; s_tag_in = 4'd3;
        @(negedge clk);
        chk("full_ready", 32'(s_cmd_ready), 32'd0);
        chk("full_busy", 32'(s_busy), 32'd1);
        chk("full_head_tag", 32'(s_res_tag), 32'd1);
        chk("full_head_res", {s_result[30:0], s_res_err}, 32'd1);
        @(posedge clk); #1; s_res_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle_ready", 32'(s_cmd_ready), 32'd0);
        chk("full_pop_cycle_valid", 32'(s_res_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_ready", 32'(s_cmd_ready), 32'd1);
        chk("after_pop_tag", 32'(s_res_tag), 32'd2);
        @(posedge clk); #1; s_cmd_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_tag", 32'(s_res_tag), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("small_empty", 32'(s_busy), 32'd0);
        @(posedge clk); #1; s_res_ready = 1'b0;

        // Reset in the middle of a DIV: outputs clear at once, result is lost.
        res_ready = 1'b1;
        send(CMD_FPU_SP_DIV, 32'h40000000, 32'h3F800000, 4'd12, 32'h40000000, 1'b0, ca);
        @(negedge clk);
        chk("div_inflight_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst_result", result, 32'd0);
        chk("arst_res_tag", 32'(res_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_valid", 32'(res_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
